alu_mdu: RTL

//   Parametrised execute-stage unit. The combinational ALU path gains shift/logic/LUI modes and a WIDTH parameter.
//   A sequential multiply/divide unit with HI/LO registers, a start/busy handshake and flush is added.

---
 rtl/alu_mdu_if.sv | 30 +++
 rtl/alu_mdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_if.sv
// Execute-stage bus: ALU operands/result and mul/div control.
// HI/LO and busy come back to the issuing stage.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] ar;
  logic             overflow;
  logic [2:0]       md_op;
  logic             start;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output src_a, src_b, shamt, alu_ctrl,
    output md_op, start, flush,
    input  ar, overflow, busy, hi, lo
  );

  modport slave (
    input  src_a, src_b, shamt, alu_ctrl,
    input  md_op, start, flush,
    output ar, overflow, busy, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// E-stage ALU plus multi-cycle mul/div with HI/LO.
// Result is computed at launch; the counter only models latency.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic       clk,
  input logic       reset_n,
  alu_mdu_if.slave  bus
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES)
                      ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_e;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  assign a = bus.src_a;
  assign b = bus.src_b;

  // ---------------- ALU ----------------
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] ar_c;
  logic             ovf_c;

  assign sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    ar_c  = '0;
    ovf_c = 1'b0;
    case (bus.alu_ctrl)
      4'd0:  ar_c = a & b;
      4'd1:  ar_c = a | b;
      4'd2: begin
        ar_c  = sum[WIDTH-1:0];
        ovf_c = sum[WIDTH] ^ sum[WIDTH-1];
      end
      4'd3:  ar_c = {{(WIDTH-1){1'b0}},
                     $signed(a) < $signed(b)};
      4'd4:  ar_c = {{(WIDTH-1){1'b0}}, a < b};
      4'd5:  ar_c = a ^ b;
      4'd6: begin
        ar_c  = diff[WIDTH-1:0];
        ovf_c = diff[WIDTH] ^ diff[WIDTH-1];
      end
      4'd7:  ar_c = ~(a | b);
      4'd8:  ar_c = b << bus.shamt;
      4'd9:  ar_c = b >> bus.shamt;
      4'd10: ar_c = $signed(b) >>> bus.shamt;
      4'd11: ar_c = b << a[4:0];
      4'd12: ar_c = b >> a[4:0];
      4'd13: ar_c = $signed(b) >>> a[4:0];
      4'd14: ar_c = b << 16;
      default: ar_c = '0;
    endcase
  end

  assign bus.ar       = ar_c;
  assign bus.overflow = ovf_c;

  // ---------------- MDU ----------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   quo_u, rem_u;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a}
                * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a}
                * {{WIDTH{1'b0}}, b};

  // Zero divisor keeps HI/LO; MIN/-1 is pinned explicitly
  always_comb begin
    quo_s = lo_q;
    rem_s = hi_q;
    quo_u = lo_q;
    rem_u = hi_q;
    if (b != '0) begin
      quo_u = a / b;
      rem_u = a % b;
      if (a == SMIN && b == '1) begin
        quo_s = SMIN;
        rem_s = '0;
      end else begin
        quo_s = $signed(a) / $signed(b);
        rem_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.md_op)
            MD_MULT: begin
              phi_d   = prod_s[2*WIDTH-1:WIDTH];
              plo_d   = prod_s[WIDTH-1:0];
              cnt_d   = CW'(MUL_CYCLES);
              state_d = RUN;
            end
            MD_MULTU: begin
              phi_d   = prod_u[2*WIDTH-1:WIDTH];
              plo_d   = prod_u[WIDTH-1:0];
              cnt_d   = CW'(MUL_CYCLES);
              state_d = RUN;
            end
            MD_DIV: begin
              phi_d   = rem_s;
              plo_d   = quo_s;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            MD_DIVU: begin
              phi_d   = rem_u;
              plo_d   = quo_u;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
